// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared states, keycodes, status bit indices and popcount for the game controller
package game_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_SELECT,
        S_PLAY,
        S_PAUSE,
        S_RESPAWN,
        S_WIN,
        S_LOSE
    } state_t;

    localparam logic [7:0] KEY_SPACE = 8'h2C;
    localparam logic [7:0] KEY_ESC   = 8'h29;
    localparam logic [7:0] KEY_P     = 8'h13;
    localparam logic [7:0] KEY_1     = 8'h1E;

    localparam int STATUS_RESPAWN = 6;
    localparam int STATUS_PAUSE   = 5;
    localparam int STATUS_SELECT  = 4;
    localparam int STATUS_WAIT    = 3;
    localparam int STATUS_PLAY    = 2;
    localparam int STATUS_WIN     = 1;
    localparam int STATUS_LOSE    = 0;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/game_fsm_multi_if.sv
// rtl/game_fsm_multi_if.sv - game controller signal bundle with master/slave modports
interface game_fsm_multi_if #(
    parameter int NUM_COINS  = 3,
    parameter int NUM_LEVELS = 2
);
    logic                  frame_clk;
    logic [7:0]            keycode;
    logic [9:0]            StickmanTop;
    logic [9:0]            GroundY;
    logic [11:0]           frame_counter;
    logic [12:0]           CoinFrameX [NUM_COINS];
    logic [9:0]            CoinY [NUM_COINS];
    logic [NUM_COINS-1:0]  CoinStatus;
    logic [NUM_LEVELS-1:0] level_status;
    logic [6:0]            status;
    logic [2:0]            lives;
    logic [4:0]            score;
    logic                  freeze;

    modport master (
        output frame_clk, keycode, StickmanTop, GroundY, frame_counter, CoinFrameX, CoinY,
        input  CoinStatus, level_status, status, lives, score, freeze
    );

    modport slave (
        input  frame_clk, keycode, StickmanTop, GroundY, frame_counter, CoinFrameX, CoinY,
        output CoinStatus, level_status, status, lives, score, freeze
    );
endinterface

// File: rtl/edge_event.sv
// rtl/edge_event.sv - registered change detector that fires only when the new value is nonzero
module edge_event #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic             ev
);
    logic [WIDTH-1:0] d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= '0;
        end else begin
            d_q <= d;
        end
    end

    // For a 1-bit input this reduces to a rising-edge strobe.
    assign ev = (d != d_q) && (d != '0);
endmodule

// File: rtl/game_fsm_multi.sv
// rtl/game_fsm_multi.sv - multi-level, multi-life game state machine with pause, respawn and score
module game_fsm_multi
    import game_pkg::*;
#(
    parameter int NUM_COINS      = 3,
    parameter int NUM_LEVELS     = 2,
    parameter int LIVES          = 3,
    parameter int WIN_FRAMES     = 3000,
    parameter int RESPAWN_FRAMES = 120,
    parameter int STICK_X        = 100,
    parameter int STICK_H        = 50,
    parameter int FLOOR_Y        = 470
) (
    input  logic             Clk,
    input  logic             Reset,
    game_fsm_multi_if.slave  bus
);
    localparam int TW = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);

    state_t                state, state_n;
    logic [NUM_COINS-1:0]  coin_q, coin_n, hit, newly;
    logic [NUM_LEVELS-1:0] level_q, level_n, digit_onehot;
    logic [2:0]            lives_q, lives_n;
    logic [4:0]            score_q, score_n, score_sat;
    logic [5:0]            score_sum;
    logic [TW-1:0]         timer_q, timer_n;
    logic                  key_ev, tick, hazard;
    logic                  key_space, key_esc, key_p, key_digit;
    logic [7:0]            digit_off;
    logic [10:0]           stick_bot, y_lo, y_hi;
    logic [12:0]           x_lo, x_hi;

    edge_event #(.WIDTH(8)) u_key_ev (
        .clk (Clk),
        .rst (Reset),
        .d   (bus.keycode),
        .ev  (key_ev)
    );

    edge_event #(.WIDTH(1)) u_frame_tick (
        .clk (Clk),
        .rst (Reset),
        .d   (bus.frame_clk),
        .ev  (tick)
    );

    assign key_space = key_ev && (bus.keycode == KEY_SPACE);
    assign key_esc   = key_ev && (bus.keycode == KEY_ESC);
    assign key_p     = key_ev && (bus.keycode == KEY_P);
    assign digit_off = bus.keycode - KEY_1;
    assign key_digit = key_ev && (bus.keycode >= KEY_1) && (digit_off < 8'(NUM_LEVELS));

    always_comb begin
        digit_onehot = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            digit_onehot[i] = (digit_off == 8'(i));
        end
    end

    // Widened by one bit so a stickman near the bottom cannot wrap past the floor line.
    assign stick_bot = {1'b0, bus.StickmanTop} + 11'(STICK_H);
    assign hazard    = (stick_bot > {1'b0, bus.GroundY}) || (stick_bot >= 11'(FLOOR_Y));

    assign x_lo = 13'(STICK_X) + {1'b0, bus.frame_counter} + 13'd10;
    assign x_hi = 13'(STICK_X) + {1'b0, bus.frame_counter} + 13'd46;
    assign y_lo = {1'b0, bus.StickmanTop} + 11'd10;
    assign y_hi = {1'b0, bus.StickmanTop} + 11'd74;

    generate
        for (genvar g = 0; g < NUM_COINS; g++) begin : g_coin
            assign hit[g] = (bus.CoinFrameX[g] > x_lo) && (bus.CoinFrameX[g] < x_hi) &&
                            ({1'b0, bus.CoinY[g]} > y_lo) && ({1'b0, bus.CoinY[g]} < y_hi);
        end
    endgenerate

    assign newly     = hit & coin_q;
    assign score_sum = {1'b0, score_q} + {1'b0, popcount16(16'(newly))};
    assign score_sat = (score_sum > 6'd31) ? 5'd31 : score_sum[4:0];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= S_WAIT;
            coin_q  <= '1;
            level_q <= NUM_LEVELS'(1);
            lives_q <= 3'(LIVES);
            score_q <= '0;
            timer_q <= '0;
        end else begin
            state   <= state_n;
            coin_q  <= coin_n;
            level_q <= level_n;
            lives_q <= lives_n;
            score_q <= score_n;
            timer_q <= timer_n;
        end
    end

    always_comb begin
        state_n = state;
        coin_n  = coin_q;
        level_n = level_q;
        lives_n = lives_q;
        score_n = score_q;
        timer_n = timer_q;

        // Coins are collected on every PLAY cycle, including the one that ends in a hazard.
        if (state == S_PLAY) begin
            coin_n  = coin_q & ~hit;
            score_n = score_sat;
        end

        case (state)
            S_WAIT: begin
                coin_n = '1;
                if (key_space) state_n = S_SELECT;
            end
            S_SELECT: begin
                if (key_digit) begin
                    state_n = S_PLAY;
                    level_n = digit_onehot;
                    lives_n = 3'(LIVES);
                    score_n = '0;
                end else if (key_esc) begin
                    state_n = S_WAIT;
                end
            end
            S_PLAY: begin
                if (hazard) begin
                    if (lives_q > 3'd1) begin
                        state_n = S_RESPAWN;
                        lives_n = lives_q - 3'd1;
                        timer_n = TW'(RESPAWN_FRAMES);
                    end else begin
                        state_n = S_LOSE;
                        lives_n = '0;
                    end
                end else if (bus.frame_counter >= 12'(WIN_FRAMES)) begin
                    state_n = S_WIN;
                end else if (key_p) begin
                    state_n = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (key_p)        state_n = S_PLAY;
                else if (key_esc) state_n = S_WAIT;
            end
            S_RESPAWN: begin
                if (tick) begin
                    timer_n = timer_q - TW'(1);
                    if (timer_q == TW'(1)) state_n = S_PLAY;
                end
            end
            S_WIN, S_LOSE: begin
                if (key_space) state_n = S_WAIT;
            end
            default: state_n = S_WAIT;
        endcase
    end

    always_comb begin
        bus.status = '0;
        case (state)
            S_WAIT:    bus.status[STATUS_WAIT]    = 1'b1;
            S_SELECT:  bus.status[STATUS_SELECT]  = 1'b1;
            S_PLAY:    bus.status[STATUS_PLAY]    = 1'b1;
            S_PAUSE:   bus.status[STATUS_PAUSE]   = 1'b1;
            S_RESPAWN: bus.status[STATUS_RESPAWN] = 1'b1;
            S_WIN:     bus.status[STATUS_WIN]     = 1'b1;
            S_LOSE:    bus.status[STATUS_LOSE]    = 1'b1;
            default:   bus.status                 = '0;
        endcase
    end

    assign bus.freeze       = (state != S_PLAY);
    assign bus.CoinStatus   = coin_q;
    assign bus.level_status = level_q;
    assign bus.lives        = lives_q;
    assign bus.score        = score_q;
endmodule

// File: tb/tb_game_fsm_multi.sv
// tb/tb_game_fsm_multi.sv - directed bench with a behavioural game model checked every cycle
module tb_game_fsm_multi;
    localparam logic [6:0] M_RESP   = 7'b1000000;
    localparam logic [6:0] M_PAUSE  = 7'b0100000;
    localparam logic [6:0] M_SELECT = 7'b0010000;
    localparam logic [6:0] M_WAIT   = 7'b0001000;
    localparam logic [6:0] M_PLAY   = 7'b0000100;
    localparam logic [6:0] M_WIN    = 7'b0000010;
    localparam logic [6:0] M_LOSE   = 7'b0000001;

    logic clk;
    logic rst;
    bit   checking;
    int   n_checks;
    int   n_fail;

    game_fsm_multi_if #(.NUM_COINS(3), .NUM_LEVELS(2)) bus ();

    game_fsm_multi dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [6:0] m_st;
    logic [2:0] m_coins;
    logic [1:0] m_level;
    int         m_lives, m_score, m_left, m_kprev, m_n, m_kc, m_bot, m_xl, m_yl, m_cx, m_cy;
    bit         m_fprev, m_kev, m_tick, m_haz;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_st = M_WAIT; m_coins = 3'b111; m_level = 2'b01;
            m_lives = 3; m_score = 0; m_left = 0; m_kprev = 0; m_fprev = 0;
        end else begin
            m_kc    = int'(bus.keycode);
            m_kev   = (m_kc != 0) && (m_kc != m_kprev);
            m_tick  = bus.frame_clk && !m_fprev;
            m_kprev = m_kc;
            m_fprev = bus.frame_clk;
            m_bot   = int'(bus.StickmanTop) + 50;
            m_haz   = (m_bot > int'(bus.GroundY)) || (m_bot >= 470);
            if (m_st == M_PLAY) begin
                m_n  = 0;
                m_xl = 100 + int'(bus.frame_counter);
                m_yl = int'(bus.StickmanTop);
                for (int i = 0; i < 3; i++) begin
                    m_cx = int'(bus.CoinFrameX[i]);
                    m_cy = int'(bus.CoinY[i]);
                    if (m_coins[i] && m_cx > m_xl + 10 && m_cx < m_xl + 46 &&
                        m_cy > m_yl + 10 && m_cy < m_yl + 74) begin
                        m_coins[i] = 1'b0;
                        m_n++;
                    end
                end
                m_score = (m_score + m_n > 31) ? 31 : m_score + m_n;
            end
            case (m_st)
                M_WAIT: begin
                    m_coins = 3'b111;
                    if (m_kev && m_kc == 'h2C) m_st = M_SELECT;
                end
                M_SELECT: begin
                    if (m_kev && m_kc >= 'h1E && m_kc < 'h1E + 2) begin
                        m_st = M_PLAY; m_level = (m_kc == 'h1E) ? 2'b01 : 2'b10;
                        m_lives = 3; m_score = 0;
                    end else if (m_kev && m_kc == 'h29) m_st = M_WAIT;
                end
                M_PLAY: begin
                    if (m_haz && m_lives > 1) begin
                        m_st = M_RESP; m_lives--; m_left = 120;
                    end else if (m_haz) begin
                        m_st = M_LOSE; m_lives = 0;
                    end else if (int'(bus.frame_counter) >= 3000) m_st = M_WIN;
                    else if (m_kev && m_kc == 'h13) m_st = M_PAUSE;
                end
                M_PAUSE: begin
                    if (m_kev && m_kc == 'h13) m_st = M_PLAY;
                    else if (m_kev && m_kc == 'h29) m_st = M_WAIT;
                end
                M_RESP: begin
                    if (m_tick) begin
                        m_left--;
                        if (m_left == 0) m_st = M_PLAY;
                    end
                end
                default: begin
                    if (m_kev && m_kc == 'h2C) m_st = M_WAIT;
                end
            endcase
        end
    endtask

    always @(posedge clk) model_update();

    always @(negedge clk) begin
        if (checking) begin
            check("m_status", int'(bus.status), int'(m_st));
            check("m_freeze", int'(bus.freeze), int'(m_st != M_PLAY));
            check("m_lives", int'(bus.lives), m_lives);
            check("m_score", int'(bus.score), m_score);
            check("m_coins", int'(bus.CoinStatus), int'(m_coins));
            check("m_level", int'(bus.level_status), int'(m_level));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] k);
        bus.keycode = k;
        step(1);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            bus.frame_clk = 1'b1;
            step(1);
            bus.frame_clk = 1'b0;
            step(1);
        end
    endtask

    task automatic hazard(input bit on);
        bus.StickmanTop = on ? 10'd400 : 10'd200;
        bus.GroundY     = on ? 10'd440 : 10'd300;
    endtask

    task automatic coins_away();
        for (int i = 0; i < 3; i++) begin
            bus.CoinFrameX[i] = 13'd1000;
            bus.CoinY[i]      = 10'd0;
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; checking = 1'b0; n_checks = 0; n_fail = 0;
        bus.frame_clk = 1'b0; bus.keycode = 8'h00; bus.frame_counter = 12'd0;
        hazard(1'b0);
        coins_away();
        step(3);
        rst = 1'b0;
        checking = 1'b1;
        check("reset_status", int'(bus.status), 'b0001000);
        check("reset_freeze", int'(bus.freeze), 1);
        check("reset_lives", int'(bus.lives), 3);
        check("reset_coins", int'(bus.CoinStatus), 'b111);
        check("reset_level", int'(bus.level_status), 'b01);

        press(8'h2C); step(9);
        check("held_space_select", int'(bus.status), 'b0010000);
        press(8'h00); press(8'h20);
        check("digit3_ignored", int'(bus.status), 'b0010000);
        press(8'h1F);
        check("digit2_play", int'(bus.status), 'b0000100);
        check("digit2_level", int'(bus.level_status), 'b10);
        check("digit2_lives", int'(bus.lives), 3);
        press(8'h00);

        bus.CoinFrameX[0] = 13'd130; bus.CoinY[0] = 10'd250;
        bus.CoinFrameX[2] = 13'd130; bus.CoinY[2] = 10'd250;
        step(1);
        check("coin_status", int'(bus.CoinStatus), 'b010);
        check("coin_score", int'(bus.score), 2);
        step(3);
        check("coin_score_hold", int'(bus.score), 2);
        coins_away();

        hazard(1'b1); step(1);
        check("hazard1_respawn", int'(bus.status), 'b1000000);
        check("hazard1_lives", int'(bus.lives), 2);
        tick(10);
        check("respawn_hazard_lives", int'(bus.lives), 2);
        hazard(1'b0); tick(109);
        check("respawn_119_ticks", int'(bus.status), 'b1000000);
        tick(1);
        check("respawn_120_ticks", int'(bus.status), 'b0000100);

        press(8'h13);
        check("pause", int'(bus.status), 'b0100000);
        press(8'h00);
        hazard(1'b1); step(3);
        check("pause_hazard_lives", int'(bus.lives), 2);
        hazard(1'b0);
        press(8'h13);
        check("unpause", int'(bus.status), 'b0000100);
        press(8'h00);

        hazard(1'b1); bus.frame_counter = 12'd3000; step(1);
        check("hazard_beats_win", int'(bus.status), 'b1000000);
        check("hazard2_lives", int'(bus.lives), 1);
        hazard(1'b0); bus.frame_counter = 12'd0;
        tick(120);
        hazard(1'b1); step(1);
        check("lose", int'(bus.status), 'b0000001);
        check("lose_lives", int'(bus.lives), 0);
        hazard(1'b0);
        press(8'h2C);
        check("lose_to_wait", int'(bus.status), 'b0001000);
        step(3);
        check("wait_coins", int'(bus.CoinStatus), 'b111);
        check("held_space_stays_wait", int'(bus.status), 'b0001000);

        press(8'h00); press(8'h2C); press(8'h1F); press(8'h00);
        bus.CoinFrameX[1] = 13'd130; bus.CoinY[1] = 10'd250; step(1);
        check("game2_score", int'(bus.score), 1);
        coins_away();
        hazard(1'b1); step(1); hazard(1'b0);
        tick(60);
        rst = 1'b1; step(1);
        check("midreset_status", int'(bus.status), 'b0001000);
        check("midreset_lives", int'(bus.lives), 3);
        check("midreset_score", int'(bus.score), 0);
        check("midreset_level", int'(bus.level_status), 'b01);
        rst = 1'b0;

        press(8'h2C); press(8'h1E); press(8'h00);
        bus.frame_counter = 12'd3000; step(1);
        check("win", int'(bus.status), 'b0000010);
        bus.frame_counter = 12'd0;
        press(8'h2C);
        check("win_to_wait", int'(bus.status), 'b0001000);
        press(8'h00); step(2);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
